vx_mem_batch_unit: RTL

Parametrised request batcher/response unbatcher between a wide core-side memory port (LSU, texture, raster or ROP units) and a narrower cache port with NUM_OUTPUTS lanes.
- Captures one wide request and issues it as ceil(NUM_INPUTS/NUM_OUTPUTS) sequential batches.
- Appends the batch index to the tag (the batch-select bits in the cache tag layout).
- Re-expands each cache response into its lane positions on the wide response port.
- Generalises the fixed LSU/DCACHE batching to any lane ratio and tag width, and adds optional empty-batch skipping.

---
 rtl/vx_mem_batch_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vx_mem_batch_unit.sv
// rtl/vx_mem_batch_unit.sv - wide-to-narrow memory request batcher and response unbatcher
// Optional MEM_BATCH_SKIP_EMPTY_EN: skip batches whose lane mask is all zero.
module vx_mem_batch_unit #(
  parameter int NUM_INPUTS   = 4,
  parameter int NUM_OUTPUTS  = 2,
  parameter int ADDR_WIDTH   = 30,
  parameter int WORD_SIZE    = 4,
  parameter int TAG_WIDTH    = 8,
  localparam int NUM_BATCHES = (NUM_INPUTS + NUM_OUTPUTS - 1) / NUM_OUTPUTS,
  localparam int BSEL_BITS   = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1,
  localparam int MTAG_WIDTH  = TAG_WIDTH + BSEL_BITS,
  localparam int DATA_WIDTH  = WORD_SIZE * 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  input  logic                                req_rw,
  input  logic [NUM_INPUTS-1:0]               req_mask,
  input  logic [NUM_INPUTS*WORD_SIZE-1:0]     req_byteen,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]    req_data,
  input  logic [TAG_WIDTH-1:0]                req_tag,
  output logic                                req_ready,
  output logic                                mem_req_valid,
  output logic                                mem_req_rw,
  output logic [NUM_OUTPUTS-1:0]              mem_req_mask,
  output logic [NUM_OUTPUTS*WORD_SIZE-1:0]    mem_req_byteen,
  output logic [NUM_OUTPUTS*ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   mem_req_data,
  output logic [MTAG_WIDTH-1:0]               mem_req_tag,
  input  logic                                mem_req_ready,
  input  logic                                mem_rsp_valid,
  input  logic [NUM_OUTPUTS-1:0]              mem_rsp_mask,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [MTAG_WIDTH-1:0]               mem_rsp_tag,
  output logic                                mem_rsp_ready,
  output logic                                rsp_valid,
  output logic [NUM_INPUTS-1:0]               rsp_mask,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]    rsp_data,
  output logic [TAG_WIDTH-1:0]                rsp_tag,
  input  logic                                rsp_ready
);

  // Captured request is zero-padded to a whole number of batches, so the
  // lanes past NUM_INPUTS in the last batch come out as zero for free.
  localparam int PAD_LANES = NUM_BATCHES * NUM_OUTPUTS;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                             state, state_n;
  logic [BSEL_BITS-1:0]               bsel, bsel_n;
  logic                               capture;
  logic                               cap_rw;
  logic [PAD_LANES-1:0]               cap_mask;
  logic [PAD_LANES*WORD_SIZE-1:0]     cap_byteen;
  logic [PAD_LANES*ADDR_WIDTH-1:0]    cap_addr;
  logic [PAD_LANES*DATA_WIDTH-1:0]    cap_data;
  logic [TAG_WIDTH-1:0]               cap_tag;

  logic [BSEL_BITS-1:0]               first_bsel;
  logic [BSEL_BITS-1:0]               next_bsel;
  logic                               is_last;
  logic                               req_empty;

`ifdef MEM_BATCH_SKIP_EMPTY_EN
  logic [PAD_LANES-1:0]   req_mask_pad;
  logic [NUM_BATCHES-1:0] req_nz;
  logic [NUM_BATCHES-1:0] cap_nz;

  assign req_mask_pad = PAD_LANES'(req_mask);
  assign req_empty    = ~|req_mask;

  always_comb begin
    for (int i = 0; i < NUM_BATCHES; i++) begin
      req_nz[i] = |req_mask_pad[i*NUM_OUTPUTS +: NUM_OUTPUTS];
      cap_nz[i] = |cap_mask[i*NUM_OUTPUTS +: NUM_OUTPUTS];
    end
  end

  // Descending scan leaves the lowest qualifying batch in each result.
  always_comb begin
    first_bsel = '0;
    next_bsel  = bsel;
    is_last    = 1'b1;
    for (int i = NUM_BATCHES - 1; i >= 0; i--) begin
      if (req_nz[i]) first_bsel = BSEL_BITS'(i);
      if (cap_nz[i] && (i > int'(bsel))) begin
        next_bsel = BSEL_BITS'(i);
        is_last   = 1'b0;
      end
    end
  end
`else
  localparam logic [BSEL_BITS-1:0] LAST_BSEL = BSEL_BITS'(NUM_BATCHES - 1);

  assign first_bsel = '0;
  assign next_bsel  = bsel + 1'b1;
  assign is_last    = (bsel == LAST_BSEL);
  assign req_empty  = 1'b0;
`endif

  assign mem_req_valid = (state == ISSUE);

  always_comb begin
    state_n   = state;
    bsel_n    = bsel;
    capture   = 1'b0;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          if (!req_empty) begin
            state_n = ISSUE;
            bsel_n  = first_bsel;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          if (is_last) begin
            req_ready = 1'b1;
            if (req_valid && !req_empty) begin
              capture = 1'b1;
              bsel_n  = first_bsel;
            end else begin
              capture = req_valid;
              state_n = IDLE;
              bsel_n  = '0;
            end
          end else begin
            bsel_n = next_bsel;
          end
        end
      end
      default: begin
        state_n = IDLE;
        bsel_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bsel  <= '0;
    end else begin
      state <= state_n;
      bsel  <= bsel_n;
      if (capture) begin
        cap_rw     <= req_rw;
        cap_mask   <= PAD_LANES'(req_mask);
        cap_byteen <= (PAD_LANES*WORD_SIZE)'(req_byteen);
        cap_addr   <= (PAD_LANES*ADDR_WIDTH)'(req_addr);
        cap_data   <= (PAD_LANES*DATA_WIDTH)'(req_data);
        cap_tag    <= req_tag;
      end
    end
  end

  always_comb begin
    mem_req_mask   = '0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    for (int i = 0; i < NUM_BATCHES; i++) begin
      if (int'(bsel) == i) begin
        mem_req_mask   = cap_mask[i*NUM_OUTPUTS +: NUM_OUTPUTS];
        mem_req_byteen = cap_byteen[i*NUM_OUTPUTS*WORD_SIZE +: NUM_OUTPUTS*WORD_SIZE];
        mem_req_addr   = cap_addr[i*NUM_OUTPUTS*ADDR_WIDTH +: NUM_OUTPUTS*ADDR_WIDTH];
        mem_req_data   = cap_data[i*NUM_OUTPUTS*DATA_WIDTH +: NUM_OUTPUTS*DATA_WIDTH];
      end
    end
  end

  assign mem_req_rw  = cap_rw;
  assign mem_req_tag = {cap_tag, bsel};

  logic [BSEL_BITS-1:0]             rsp_bsel;
  logic [NUM_INPUTS-1:0]            rsp_mask_n;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] rsp_data_n;
  logic                             mem_rsp_fire;

  assign rsp_bsel      = mem_rsp_tag[BSEL_BITS-1:0];
  assign mem_rsp_ready = !rsp_valid || rsp_ready;
  assign mem_rsp_fire  = mem_rsp_valid && mem_rsp_ready;

  // Each wide lane k is fed only by cache lane k%NUM_OUTPUTS of batch k/NUM_OUTPUTS.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_rsp_lane
    localparam int LB = k / NUM_OUTPUTS;
    localparam int LJ = k % NUM_OUTPUTS;
    assign rsp_mask_n[k] = (int'(rsp_bsel) == LB) && mem_rsp_mask[LJ];
    assign rsp_data_n[k*DATA_WIDTH +: DATA_WIDTH] =
      (int'(rsp_bsel) == LB) ? mem_rsp_data[LJ*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_mask  <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else if (mem_rsp_fire) begin
      rsp_valid <= 1'b1;
      rsp_mask  <= rsp_mask_n;
      rsp_data  <= rsp_data_n;
      rsp_tag   <= mem_rsp_tag[MTAG_WIDTH-1 -: TAG_WIDTH];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
